// File: rtl/step_scheduler.sv
// Playback sequencer: emits a step tick at a BPM-derived rate, tracks the
// current step and completed loops, and reports natural completion.
module step_scheduler #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned STEPS          = 16,
    parameter int unsigned STEPS_PER_BEAT = 4,
    parameter int unsigned MIN_BPM        = 30,
    parameter int unsigned MAX_BPM        = 300
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic [9:0]               BPM,
    input  logic [6:0]               Loops,
    output logic                     play_en,
    output logic                     step_tick,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic [6:0]               loop_cnt,
    output logic                     done
);

    localparam int unsigned IW = $clog2(STEPS);

    // One step is due each time the accumulator passes 60 s worth of clock cycles.
    localparam logic [32:0]   THRESH = 33'(64'(CLK_HZ) * 64'd60);
    localparam logic [9:0]    MIN_B  = 10'(MIN_BPM);
    localparam logic [9:0]    MAX_B  = 10'(MAX_BPM);
    localparam logic [IW-1:0] LAST   = IW'(STEPS - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StFinish} state_e;

    state_e          state_q, state_d;
    logic            start_q;
    logic [31:0]     acc_q, acc_d;
    logic [9:0]      bpm_q, bpm_d;
    logic [6:0]      loops_q, loops_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [6:0]      loop_q, loop_d;
    logic            tick_q, tick_d;

    logic [32:0]     inc;
    logic [32:0]     sum;
    logic [6:0]      loop_inc;

    assign inc      = 33'(bpm_q) * 33'(STEPS_PER_BEAT);
    assign sum      = {1'b0, acc_q} + inc;
    assign loop_inc = (loop_q == 7'd127) ? loop_q : loop_q + 7'd1;

    // Next-state logic: start capture, accumulator stepping, wrap/finish decision.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bpm_d   = bpm_q;
        loops_d = loops_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start && !start_q && !Stop) begin
                    state_d = StPlay;
                    bpm_d   = (BPM < MIN_B) ? MIN_B : ((BPM > MAX_B) ? MAX_B : BPM);
                    loops_d = Loops;
                    acc_d   = '0;
                    idx_d   = '0;
                    loop_d  = '0;
                    tick_d  = 1'b1;  // first step sounds on entry
                end
            end
            StPlay: begin
                if (Stop) begin
                    // Abort wins over any coincident step or final wrap.
                    state_d = StIdle;
                end else if (sum >= THRESH) begin
                    acc_d = 32'(sum - THRESH);
                    if (idx_q != LAST) begin
                        idx_d  = idx_q + IW'(1);
                        tick_d = 1'b1;
                    end else begin
                        loop_d = loop_inc;
                        if (loops_q != 7'd0 && loop_inc == loops_q) begin
                            state_d = StFinish;  // index holds on the last step
                        end else begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end
                    end
                end else begin
                    acc_d = sum[31:0];
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State registers; start_q resets high so a held Start cannot trigger.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            start_q <= 1'b1;
            acc_q   <= '0;
            bpm_q   <= '0;
            loops_q <= '0;
            idx_q   <= '0;
            loop_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= Start;
            acc_q   <= acc_d;
            bpm_q   <= bpm_d;
            loops_q <= loops_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            tick_q  <= tick_d;
        end
    end

    assign play_en   = (state_q == StPlay);
    assign done      = (state_q == StFinish);
    assign step_tick = tick_q;
    assign step_idx  = idx_q;
    assign loop_cnt  = loop_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: each run is predicted from the tempo rule
// (step n is due ceil(n*60*CLK_HZ / (bpm*STEPS_PER_BEAT)) cycles after entry).
module tb_step_scheduler;

    localparam int unsigned CLK_HZ = 240;
    localparam int unsigned STEPS  = 4;
    localparam int unsigned SPB    = 4;
    localparam longint      T      = 60 * CLK_HZ;

    logic       clk = 1'b0;
    logic       reset;
    logic       Start;
    logic       Stop;
    logic [9:0] BPM;
    logic [6:0] Loops;
    logic       play_en;
    logic       step_tick;
    logic [1:0] step_idx;
    logic [6:0] loop_cnt;
    logic       done;

    int checks = 0;
    int errors = 0;

    step_scheduler #(
        .CLK_HZ        (CLK_HZ),
        .STEPS         (STEPS),
        .STEPS_PER_BEAT(SPB),
        .MIN_BPM       (30),
        .MAX_BPM       (300)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .Start    (Start),
        .Stop     (Stop),
        .BPM      (BPM),
        .Loops    (Loops),
        .play_en  (play_en),
        .step_tick(step_tick),
        .step_idx (step_idx),
        .loop_cnt (loop_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int p, input int t, input int d,
                           input int i, input int l);
        chk({tag, ".play_en"}, int'(play_en), p);
        chk({tag, ".step_tick"}, int'(step_tick), t);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".step_idx"}, int'(step_idx), i);
        chk({tag, ".loop_cnt"}, int'(loop_cnt), l);
    endtask

    function automatic longint clampb(input int b);
        return (b < 30) ? 30 : ((b > 300) ? 300 : b);
    endfunction

    // Cycle (relative to the entry cycle) at which step n becomes visible.
    function automatic longint due(input longint n, input longint inc);
        return (n * T + inc - 1) / inc;
    endfunction

    // kind: 0 = run to completion, 1 = Stop during cycle abort_at, 2 = reset then.
    task automatic run(input string tag, input int bpm, input int loops,
                       input int abort_at, input int kind);
        longint inc;
        longint k;
        int     cur;
        int     e_idx;
        int     e_loop;
        bit     fin;
        inc    = clampb(bpm) * SPB;
        Start  = 1'b0;
        Stop   = 1'b0;
        BPM    = 10'(bpm);
        Loops  = 7'(loops);
        step();
        Start  = 1'b1;
        step();
        cur    = 0;
        e_idx  = 0;
        e_loop = 0;
        k      = 0;
        fin    = 1'b0;
        chk_all({tag, ".entry"}, 1, 1, 0, 0, 0);
        // Tempo/loop inputs must be ignored once playing.
        Start  = 1'b0;
        BPM    = 10'($urandom_range(0, 1023));
        Loops  = 7'($urandom_range(0, 127));
        while (!fin) begin
            if (k == abort_at) begin
                if (kind == 1) Stop = 1'b1;
                else reset = 1'b1;
            end
            step();
            k++;
            Stop  = 1'b0;
            reset = 1'b0;
            if (k == abort_at + 1) begin
                if (kind == 2) chk_all({tag, ".reset"}, 0, 0, 0, 0, 0);
                else chk_all({tag, ".stop"}, 0, 0, 0, e_idx, e_loop);
                step();
                chk({tag, ".idle_after_abort"}, int'(play_en), 0);
                fin = 1'b1;
            end else if (k == due(cur + 1, inc)) begin
                if (loops != 0 && cur + 1 == loops * int'(STEPS)) begin
                    chk_all({tag, ".finish"}, 0, 0, 1, STEPS - 1, loops);
                    step();
                    chk_all({tag, ".idle"}, 0, 0, 0, STEPS - 1, loops);
                    fin = 1'b1;
                end else begin
                    cur++;
                    e_idx  = cur % STEPS;
                    e_loop = (cur / STEPS > 127) ? 127 : cur / STEPS;
                    chk_all({tag, ".tick"}, 1, 1, 0, e_idx, e_loop);
                end
            end else begin
                chk_all({tag, ".hold"}, 1, 0, 0, e_idx, e_loop);
            end
            if (k > 20000 && !fin) begin
                chk({tag, ".timeout"}, 1, 0);
                fin = 1'b1;
            end
        end
    endtask

    initial begin
        int b;
        int l;
        // Reset release with Start held high must not start playback.
        reset = 1'b1;
        Start = 1'b1;
        Stop  = 1'b0;
        BPM   = 10'd60;
        Loops = 7'd2;
        repeat (3) step();
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (5) step();
        chk_all("held_start", 0, 0, 0, 0, 0);

        run("bpm60_l2", 60, 2, -5, 0);
        run("bpm5_clamp", 5, 1, -5, 0);
        run("bpm1000_clamp", 1000, 2, -5, 0);
        // Endless run stopped after 10 loops.
        run("endless_stop", 60, 0, int'(due(41, 240)) + 5, 1);
        // Stop coincident with the final wrap: no tick, no done.
        run("stop_final", 60, 1, int'(due(STEPS, 240)) - 1, 1);
        // Reset mid-run while step_idx is 2, then a fresh start.
        run("reset_mid", 60, 1, int'(due(2, 240)) + 3, 2);
        run("restart", 60, 1, -5, 0);

        for (int r = 0; r < 4; r++) begin
            b = $urandom_range(0, 1023);
            l = $urandom_range(1, 3);
            run($sformatf("rand%0d", r), b, l, -5, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Playback sequencer for the step sequencer; consumes `BPM`, `Loops` and `Start` from the keyboard input interface.
- Generates the per-step timing tick, the current step index and the loop counter.
- Drives `play_en` back to the input interface; dropping `play_en` returns that interface to IDLE.
- Step rate derives from BPM through a phase accumulator: exact average rate, no divider.

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz.
- STEPS, 16, steps per pattern loop (power of 2, 2..256).
- STEPS_PER_BEAT, 4, steps per quarter-note beat.
- MIN_BPM, 30, lower BPM clamp.
- MAX_BPM, 300, upper BPM clamp.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  level request from input interface; rising edge starts playback.
- Stop  in  1  single-cycle abort request.
- BPM  in  10  tempo, sampled at start.
- Loops  in  7  number of pattern loops, sampled at start; 0 = play until Stop.
- play_en  out  1  high while playing.
- step_tick  out  1  one-cycle pulse at each step boundary.
- step_idx  out  clog2(STEPS)  current step, valid while `play_en`.
- loop_cnt  out  7  completed loops in the current run, saturating at 127.
- done  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset: state IDLE; `play_en`, `step_tick`, `done` = 0; `step_idx`, `loop_cnt`, accumulator = 0; `start_q` (previous Start) = 1, so a Start held high through reset does not trigger.
- States: IDLE, PLAY, FINISH.
- IDLE -> PLAY on `Start && !start_q && !Stop`. Same cycle:
  - latch `bpm_l` = clamp(BPM, MIN_BPM, MAX_BPM) and `loops_l` = Loops;
  - clear accumulator, `step_idx`, `loop_cnt`.
- Entering PLAY (first PLAY cycle): `play_en` = 1 and `step_tick` = 1 with `step_idx` = 0; the first step sounds immediately.
- Timing in PLAY, each cycle:
  - `inc` = `bpm_l` × STEPS_PER_BEAT; `THRESH` = 60 × CLK_HZ; accumulator is 32-bit unsigned.
  - If acc + inc ≥ THRESH: acc <= acc + inc − THRESH and assert `step_tick`.
  - Otherwise acc <= acc + inc.
- On each non-initial `step_tick`:
  - If `step_idx` < STEPS−1, `step_idx` increments.
  - At wrap (STEPS−1 -> 0), `loop_cnt` increments (saturating).
  - If `loops_l` ≠ 0 and the new `loop_cnt` == `loops_l`: go to FINISH instead of wrapping. No tick is emitted that cycle and `step_idx` holds STEPS−1.
- FINISH (one cycle): `play_en` = 0, `done` = 1; next state IDLE.
- Stop in PLAY: next cycle IDLE, `play_en` = 0, `done` stays 0. Stop has priority over a coincident step or final wrap, so no tick and no done are emitted.
- Start level changes during PLAY are ignored. BPM/Loops changes after start are ignored.
- `start_q` updates every cycle. A restart requires Start to go low then high again after returning to IDLE.
- `step_idx` and `loop_cnt` hold their last values in IDLE until the next start.
- Reset mid-play: next cycle all outputs are at reset values; no done pulse.

Test Plan:
- Reset release with Start held high -> stays IDLE, `play_en` = 0, no tick.
- CLK_HZ=240, STEPS=4, STEPS_PER_BEAT=4, BPM=60, Loops=2, Start rise:
  - `play_en` rises the next cycle with `step_tick` and `step_idx` = 0;
  - subsequent ticks arrive exactly every 60 cycles;
  - after the 8th step interval: FINISH, `done` 1 cycle, `loop_cnt` = 2, `play_en` = 0.
- BPM=5 -> clamped to 30, tick every 120 cycles. BPM=1000 -> clamped to 300, tick every 12 cycles.
- Loops=0, BPM=60 -> runs past 10 loops, `loop_cnt` = 10. Stop pulse -> `play_en` 0 the next cycle, `done` never asserted.
- Stop asserted in the same cycle as the final wrap tick (Loops=1) -> no tick, no done, IDLE.
- Reset asserted mid-run at `step_idx` = 2 -> all outputs 0 next cycle. A fresh Start rise restarts from `step_idx` 0.
